parity_frame_gen: RTL

Parametrised streaming parity encoder and successor to the fixed 8-bit parity generator.
- Accepts DATA_W-bit words on a valid/ready stream.
- Emits each word with a per-word parity bit appended as the LSB, matching the existing {data, parity} output format.
- After every FRAME_LEN data words, inserts one trailer word carrying the longitudinal (column-wise XOR) parity of the frame.
- Sits between a data source and a serialiser/link that needs per-word and per-frame error detection.

---
 rtl/parity_pkg.sv | 12 +
 rtl/parity_calc.sv | 12 +
 rtl/parity_frame_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared types for the streaming parity frame generator.
package parity_pkg;

    typedef enum logic {
        S_DATA  = 1'b0,
        S_TRAIL = 1'b1
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage : parity_pkg

// File: rtl/parity_calc.sv
// Combinational parity of a W-bit word; odd=1 selects odd parity.
module parity_calc #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] data,
    input  logic         odd,
    output logic         parity
);

    assign parity = (^data) ^ odd;

endmodule : parity_calc

// File: rtl/parity_frame_gen.sv
// Streaming per-word parity encoder with a longitudinal parity trailer every FRAME_LEN words.
// Optional completed-frame counter enabled by defining PARITY_FRAME_CNT_EN.
module parity_frame_gen
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned FRAME_LEN = 16
`ifdef PARITY_FRAME_CNT_EN
    ,
    parameter int unsigned CNT_W     = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              odd_mode,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W:0]   m_data,
    output logic              m_last
`ifdef PARITY_FRAME_CNT_EN
    ,
    output logic [CNT_W-1:0]  frame_cnt
`endif
);

    localparam int unsigned WC_W = $clog2(FRAME_LEN);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(FRAME_LEN - 1);

    state_t            state, state_d;
    logic [WC_W-1:0]   word_cnt, word_cnt_d;
    logic [DATA_W-1:0] lrc, lrc_d;
    logic              odd_q, odd_d;
    logic              m_valid_d, m_last_d;
    logic [DATA_W:0]   m_data_d;

    logic free_c;
    logic mode_c;
    logic data_par_c;
    logic lrc_par_c;

    assign free_c = !m_valid || m_ready;
    // Mode is latched at word 0 and held for the rest of the frame and its trailer
    assign mode_c = (word_cnt == '0) ? (odd_mode ? PAR_ODD : PAR_EVEN) : odd_q;

    parity_calc #(.W(DATA_W)) u_data_par (
        .data   (s_data),
        .odd    (mode_c),
        .parity (data_par_c)
    );

    parity_calc #(.W(DATA_W)) u_lrc_par (
        .data   (lrc),
        .odd    (odd_q),
        .parity (lrc_par_c)
    );

    // Next-state and output-register logic
    always_comb begin
        state_d    = state;
        word_cnt_d = word_cnt;
        lrc_d      = lrc;
        odd_d      = odd_q;
        m_valid_d  = m_valid;
        m_data_d   = m_data;
        m_last_d   = m_last;
        s_ready    = 1'b0;

        if (free_c) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        case (state)
            S_DATA: begin
                s_ready = free_c;
                if (s_valid && free_c) begin
                    m_data_d  = {s_data, data_par_c};
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    lrc_d     = lrc ^ s_data;
                    odd_d     = mode_c;
                    if (word_cnt == WC_LAST) begin
                        word_cnt_d = '0;
                        state_d    = S_TRAIL;
                    end else begin
                        word_cnt_d = word_cnt + WC_W'(1);
                    end
                end
            end
            S_TRAIL: begin
                if (free_c) begin
                    m_data_d  = {lrc, lrc_par_c};
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b1;
                    lrc_d     = '0;
                    state_d   = S_DATA;
                end
            end
            default: state_d = S_DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_DATA;
            word_cnt <= '0;
            lrc      <= '0;
            odd_q    <= PAR_EVEN;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_last   <= 1'b0;
        end else begin
            state    <= state_d;
            word_cnt <= word_cnt_d;
            lrc      <= lrc_d;
            odd_q    <= odd_d;
            m_valid  <= m_valid_d;
            m_data   <= m_data_d;
            m_last   <= m_last_d;
        end
    end

`ifdef PARITY_FRAME_CNT_EN
    // Counts trailer handshakes, wrapping naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (m_valid && m_ready && m_last) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end
`endif

endmodule : parity_frame_gen
